// File: rtl/udp_tx_packer.sv
// UDP transmit packer: buffers one payload frame, then streams an 8-byte UDP header
// plus the payload to the IP stage as low-nibble-first MII nibbles on demand.
module udp_tx_packer #(
  parameter logic [15:0] SRC_PORT    = 16'd5000,
  parameter logic [15:0] DST_PORT    = 16'd6000,
  parameter int          MAX_PAYLOAD = 1472
) (
  input  logic        mii_tx_clk,
  input  logic        rst,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  input  logic        wr_last,
  output logic        wr_ready,
  output logic        tx_go,
  output logic [11:0] data_len,
  input  logic        fifo_rq,
  output logic [3:0]  fifo_da,
  output logic        tx_done,
  output logic        drop_err
);

  // state  | meaning
  // IDLE   | accepting payload bytes into the buffer
  // LAUNCH | one-cycle tx_go to the IP stage
  // SEND   | serving header + payload nibbles on fifo_rq
  // DROP   | discarding the rest of an oversize frame
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] SEND   = 2'd2;
  localparam logic [1:0] DROP   = 2'd3;

  logic [1:0]  state;
  logic [10:0] wr_ptr;
  logic [11:0] nib_cnt;
  logic [10:0] rd_addr;
  logic [7:0]  mem [MAX_PAYLOAD];

  logic        wr_accept;
  logic        oversize;
  logic        store;
  logic        rd_hit;
  logic        last_nib;
  logic [12:0] nib_total;
  logic [10:0] byte_idx;
  logic [7:0]  hdr_byte;
  logic [7:0]  cur_byte;
  logic [3:0]  nibble;

  assign wr_ready  = (state == IDLE) || (state == DROP);
  assign tx_go     = (state == LAUNCH);
  assign wr_accept = wr_valid && wr_ready;
  assign oversize  = (wr_ptr == 11'(MAX_PAYLOAD));
  assign store     = wr_accept && (state == IDLE) && !oversize;
  assign nib_total = {data_len, 1'b0};
  assign rd_hit    = fifo_rq && (state == SEND) && ({1'b0, nib_cnt} < nib_total);
  assign last_nib  = ({1'b0, nib_cnt} == (nib_total - 13'd1));
  assign byte_idx  = nib_cnt[11:1];

  always_comb begin
    hdr_byte = 8'h00;
    case (byte_idx[2:0])
      3'd0:    hdr_byte = SRC_PORT[15:8];
      3'd1:    hdr_byte = SRC_PORT[7:0];
      3'd2:    hdr_byte = DST_PORT[15:8];
      3'd3:    hdr_byte = DST_PORT[7:0];
      3'd4:    hdr_byte = {4'h0, data_len[11:8]};
      3'd5:    hdr_byte = data_len[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  // rd_addr already points at the payload byte for the current nibble pair
  assign cur_byte = (byte_idx < 11'd8) ? hdr_byte : mem[rd_addr];
  assign nibble   = nib_cnt[0] ? cur_byte[7:4] : cur_byte[3:0];

  always_ff @(posedge mii_tx_clk) begin
    if (store) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge mii_tx_clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      nib_cnt  <= '0;
      rd_addr  <= '0;
      data_len <= '0;
      tx_done  <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      drop_err <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_accept) begin
            if (oversize) begin
              drop_err <= 1'b1;
              wr_ptr   <= '0;
              if (!wr_last) state <= DROP;
            end else if (wr_last) begin
              data_len <= {1'b0, wr_ptr} + 12'd9;
              wr_ptr   <= '0;
              state    <= LAUNCH;
            end else begin
              wr_ptr <= wr_ptr + 11'd1;
            end
          end
        end
        DROP: begin
          if (wr_accept && wr_last) begin
            wr_ptr <= '0;
            state  <= IDLE;
          end
        end
        LAUNCH: begin
          nib_cnt <= '0;
          rd_addr <= '0;
          state   <= SEND;
        end
        SEND: begin
          if (rd_hit) begin
            nib_cnt <= nib_cnt + 12'd1;
            if (nib_cnt[0] && (byte_idx >= 11'd8)) rd_addr <= rd_addr + 11'd1;
            if (last_nib) begin
              tx_done <= 1'b1;
              wr_ptr  <= '0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reads outside a live stream return zero instead of stale data
  always_ff @(posedge mii_tx_clk) begin
    if (rst) begin
      fifo_da <= '0;
    end else if (rd_hit) begin
      fifo_da <= nibble;
    end else if (fifo_rq) begin
      fifo_da <= '0;
    end
  end

endmodule

// File: tb/tb_udp_tx_packer.sv
// Randomized bench for udp_tx_packer: a queue-based model builds the expected
// nibble stream from the payload and the UDP header rules.
module tb_udp_tx_packer;
  localparam int MAX = 1472;
  localparam int SRC = 5000;
  localparam int DST = 6000;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_last;
  logic        wr_ready;
  logic        tx_go;
  logic [11:0] data_len;
  logic        fifo_rq;
  logic [3:0]  fifo_da;
  logic        tx_done;
  logic        drop_err;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] pay[$];

  udp_tx_packer dut (
    .mii_tx_clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_last(wr_last), .wr_ready(wr_ready), .tx_go(tx_go), .data_len(data_len),
    .fifo_rq(fifo_rq), .fifo_da(fifo_da), .tx_done(tx_done), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic fill_random(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
  endtask

  task automatic write_frame(input bit gaps);
    int  n;
    bit  drop;
    n    = pay.size();
    drop = (n > MAX);
    chk("wr_ready_idle", wr_ready, 1);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        wr_valid = 1'b0;
        @(negedge clk);
      end
      wr_valid = 1'b1;
      wr_data  = pay[i];
      wr_last  = (i == n - 1);
      @(negedge clk);
      chk("drop_err", drop_err, (i == MAX));
      if (i == n - 1) begin
        chk("tx_go", tx_go, !drop);
        if (!drop) chk("data_len", data_len, n + 8);
      end
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    if (drop) begin
      @(negedge clk);
      chk("no_tx_go_after_drop", tx_go, 0);
      chk("wr_ready_after_drop", wr_ready, 1);
    end
  endtask

  // mode 0: rq every cycle, 1: random rq, 2: alternate rq with a 5-cycle hole
  task automatic read_frame(input int mode, input bit junk);
    logic [7:0] bytes[$];
    logic [3:0] expn[$];
    int len, nn, k, cyc;
    len = pay.size() + 8;
    bytes = '{8'(SRC >> 8), 8'(SRC & 255), 8'(DST >> 8), 8'(DST & 255),
              8'(len >> 8), 8'(len & 255), 8'h00, 8'h00};
    foreach (pay[i]) bytes.push_back(pay[i]);
    foreach (bytes[i]) begin
      expn.push_back(bytes[i][3:0]);
      expn.push_back(bytes[i][7:4]);
    end
    nn  = expn.size();
    k   = 0;
    cyc = 0;
    fifo_rq = 1'b0;
    @(negedge clk);
    chk("tx_go_pulse_end", tx_go, 0);
    while (k < nn && cyc < 20000) begin
      case (mode)
        0:       fifo_rq = 1'b1;
        1:       fifo_rq = ($urandom_range(0, 2) != 0);
        default: fifo_rq = ((cyc % 2) == 0) && !(cyc >= 6 && cyc < 11);
      endcase
      if (junk) begin
        wr_valid = 1'b1;
        wr_data  = 8'($urandom);
        wr_last  = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
      if (fifo_rq) begin
        chk("nibble", fifo_da, expn[k]);
        k++;
        chk("tx_done", tx_done, (k == nn));
      end else if (k > 0) begin
        chk("hold", fifo_da, expn[k-1]);
      end
      if (junk) chk("wr_ready_send", wr_ready, (k == nn));
    end
    fifo_rq  = 1'b0;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    if (k < nn) chk("read_timeout", k, nn);
    fifo_rq = 1'b1;
    @(negedge clk);
    chk("underrun_da", fifo_da, 0);
    chk("tx_done_pulse_end", tx_done, 0);
    chk("wr_ready_after", wr_ready, 1);
    fifo_rq = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; wr_last = 1'b0; fifo_rq = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_tx_go", tx_go, 0);
    chk("rst_data_len", data_len, 0);
    chk("rst_fifo_da", fifo_da, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_drop_err", drop_err, 0);
    rst = 1'b0;
    @(negedge clk);

    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    write_frame(0);
    read_frame(0, 0);

    fill_random(20);
    write_frame(1);
    read_frame(2, 0);

    pay = '{8'hA5};
    write_frame(0);
    read_frame(1, 0);

    fill_random(10);
    write_frame(1);
    read_frame(1, 1);
    fill_random(7);
    write_frame(0);
    read_frame(0, 0);

    fill_random(1480);
    write_frame(0);
    fill_random(5);
    write_frame(0);
    read_frame(1, 0);

    fill_random(MAX + 1);
    write_frame(0);
    fill_random(3);
    write_frame(0);
    read_frame(0, 0);

    fill_random(MAX);
    write_frame(0);
    read_frame(1, 0);

    fill_random(6);
    write_frame(0);
    @(negedge clk);
    fifo_rq = 1'b1;
    repeat (9) @(negedge clk);
    fifo_rq = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_wr_ready", wr_ready, 1);
    chk("midrst_tx_go", tx_go, 0);
    chk("midrst_fifo_da", fifo_da, 0);
    rst = 1'b0;
    @(negedge clk);
    fill_random(9);
    write_frame(1);
    read_frame(2, 0);

    for (int f = 0; f < 10; f++) begin
      fill_random($urandom_range(1, 64));
      write_frame(1'($urandom));
      read_frame($urandom_range(0, 2), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
